// File: rtl/ef_dac_pkg.sv
// ef_dac_pkg: shared state encoding and constants for the ef_dac_bank DAC tile.
package ef_dac_pkg;
    localparam int STATE_W = 2;
    typedef enum logic [STATE_W-1:0] {IDLE, XFER, SLEW} dacState_t;
    localparam int RESET_CODE = 0;
    localparam int AUTO_LOAD_BIT = 0;
endpackage

// File: rtl/ef_dac_slew_ch.sv
// ef_dac_slew_ch: one channel's active code and target, stepping toward the target
// by at most SLEW_STEP per cycle without overshoot.
import ef_dac_pkg::*;
module ef_dac_slew_ch #(
    parameter int WIDTH = 8,
    parameter int SLEW_STEP = 1
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             xfer,
    input  logic             slewEn,
    input  logic [WIDTH-1:0] newTarget,
    output logic [WIDTH-1:0] value,
    output logic             near
);
    localparam logic [WIDTH-1:0] STEP = SLEW_STEP[WIDTH-1:0];
    logic [WIDTH-1:0] active, target, diff, stp;
    logic up;
    always_comb begin
        up = target > active;
        diff = up ? target - active : active - target;
        stp = diff > STEP ? STEP : diff;
        near = diff <= STEP;
    end
    always_ff @(posedge clk or negedge rstN)
        if (!rstN) begin
            active <= WIDTH'(RESET_CODE);
            target <= WIDTH'(RESET_CODE);
        end else if (xfer)
            target <= newTarget;
        else if (slewEn)
            active <= up ? active + stp : active - stp;
    assign value = active;
endmodule

// File: rtl/ef_dac_bank.sv
// ef_dac_bank: double-buffered multi-channel DAC code bank with strobed or auto load.
// Optional output slew limiting is compiled in with `define DAC_SLEW_EN.
import ef_dac_pkg::*;
module ef_dac_bank #(
    parameter int WIDTH = 8,
    parameter int CHANNELS = 4,
    parameter int CH_BITS = 2,
    parameter int SLEW_STEP = 1,
    parameter int NoConfigBits = 1
) (
    input  logic                      UserCLK,
    input  logic                      RESETN,
    input  logic                      WR_VALID,
    output logic                      WR_READY,
    input  logic [CH_BITS-1:0]        WR_CH,
    input  logic [WIDTH-1:0]          WR_DATA,
    output logic                      WR_ERR,
    input  logic                      LOAD,
    output logic                      BUSY,
    output logic [CHANNELS*WIDTH-1:0] VALUE_top,
    input  logic [NoConfigBits-1:0]   ConfigBits
);
    localparam logic [CH_BITS:0] CH_LIM = CHANNELS[CH_BITS:0];
    dacState_t state, stateNext;
    logic [WIDTH-1:0] shadow [CHANNELS];
    logic [WIDTH-1:0] active [CHANNELS];
    logic accept, validCh, goodWr, trigger, wrErr;
    assign WR_READY = state != XFER;
    assign BUSY = state != IDLE;
    assign WR_ERR = wrErr;
    assign accept = WR_VALID && WR_READY;
    assign validCh = {1'b0, WR_CH} < CH_LIM;
    assign goodWr = accept && validCh;
    assign trigger = LOAD || (ConfigBits[AUTO_LOAD_BIT] && goodWr);
`ifdef DAC_SLEW_EN
    logic [CHANNELS-1:0] near;
    logic anyDiff;
    always_comb begin
        anyDiff = 1'b0;
        for (int c = 0; c < CHANNELS; c++)
            anyDiff |= active[c] != shadow[c];
    end
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    stateNext = trigger ? XFER : IDLE;
            XFER:    stateNext = anyDiff ? SLEW : IDLE;
            default: stateNext = trigger ? XFER : (&near ? IDLE : SLEW);
        endcase
    end
    for (genvar c = 0; c < CHANNELS; c++) begin : gCh
        ef_dac_slew_ch #(.WIDTH(WIDTH), .SLEW_STEP(SLEW_STEP)) uCh (
            .clk(UserCLK),
            .rstN(RESETN),
            .xfer(state == XFER),
            .slewEn(state == SLEW),
            .newTarget(shadow[c]),
            .value(active[c]),
            .near(near[c])
        );
    end
`else
    always_comb begin
        stateNext = IDLE;
        if (state == IDLE && trigger) stateNext = XFER;
    end
    always_ff @(posedge UserCLK or negedge RESETN)
        if (!RESETN)
            for (int c = 0; c < CHANNELS; c++) active[c] <= WIDTH'(RESET_CODE);
        else if (state == XFER)
            for (int c = 0; c < CHANNELS; c++) active[c] <= shadow[c];
`endif
    // Writes to a nonexistent channel complete the handshake but only raise WR_ERR.
    always_ff @(posedge UserCLK or negedge RESETN)
        if (!RESETN) begin
            state <= IDLE;
            wrErr <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) shadow[c] <= WIDTH'(RESET_CODE);
        end else begin
            state <= stateNext;
            wrErr <= accept && !validCh;
            for (int c = 0; c < CHANNELS; c++)
                if (goodWr && WR_CH == CH_BITS'(c)) shadow[c] <= WR_DATA;
        end
    for (genvar c = 0; c < CHANNELS; c++) begin : gOut
        assign VALUE_top[c*WIDTH +: WIDTH] = active[c];
    end
endmodule
